demux1to4_buf: RTL and testbench

DEMUX1TO4_BUF -- requirements
Module: demux1to4_buf

---
 rtl/demux1to4_buf.sv | 93 +++++++++
 tb/tb_demux1to4_buf.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1to4_buf.sv
// One-to-four demultiplexer with a one-entry holding buffer per channel.
// Valid/ready input handshake; each channel is drained by its own Ack bit.
module demux1to4_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [1:0]       Selector,
    input  logic [WIDTH-1:0] Data,
    output logic [WIDTH-1:0] R0,
    output logic [WIDTH-1:0] R1,
    output logic [WIDTH-1:0] R2,
    output logic [WIDTH-1:0] R3,
    output logic [3:0]       Valid,
    input  logic [3:0]       Ack,
    output logic [15:0]      Accept_Count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      state_q [4];
    chan_state_t      state_d [4];
    logic [WIDTH-1:0] buf_q   [4];
    logic [15:0]      count_q;
    logic             accept;
    logic [3:0]       load;

    // A full channel can still accept when its consumer drains it this cycle.
    always_comb begin
        In_Ready = (state_q[Selector] == EMPTY) || Ack[Selector];
        accept   = In_Valid && In_Ready;
        load     = 4'b0000;
        if (accept) begin
            load[Selector] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                EMPTY: begin
                    if (load[i]) begin
                        state_d[i] = FULL;
                    end
                end
                FULL: begin
                    if (!load[i] && Ack[i]) begin
                        state_d[i] = EMPTY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= EMPTY;
                buf_q[i]   <= '0;
            end
            count_q <= 16'h0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                if (load[i]) begin
                    buf_q[i] <= Data;
                end
            end
            if (accept) begin
                count_q <= count_q + 16'h0001;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            Valid[i] = (state_q[i] == FULL);
        end
    end

    assign R0           = buf_q[0];
    assign R1           = buf_q[1];
    assign R2           = buf_q[2];
    assign R3           = buf_q[3];
    assign Accept_Count = count_q;

endmodule

// File: tb/tb_demux1to4_buf.sv
// Randomized and directed bench for demux1to4_buf against a behavioural
// model of four one-word mailboxes and an accept counter.
module tb_demux1to4_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [1:0]  Selector = 2'd0;
    logic [31:0] Data = '0;
    logic [31:0] R0, R1, R2, R3;
    logic [3:0]  Valid;
    logic [3:0]  Ack = 4'b0000;
    logic [15:0] Accept_Count;

    int tests = 0;
    int fails = 0;

    logic [31:0] mr [4];
    bit          mv [4];
    int          mcnt = 0;

    demux1to4_buf #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .In_Valid(In_Valid),
        .In_Ready(In_Ready),
        .Selector(Selector),
        .Data(Data),
        .R0(R0),
        .R1(R1),
        .R2(R2),
        .R3(R3),
        .Valid(Valid),
        .Ack(Ack),
        .Accept_Count(Accept_Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = mv[i];
        return v;
    endfunction

    function automatic bit model_ready(input logic [1:0] s,
                                       input logic [3:0] a);
        return !mv[s] || a[s];
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".valid"}, {28'd0, Valid}, {28'd0, model_valid()});
        check({tag, ".r0"}, R0, mr[0]);
        check({tag, ".r1"}, R1, mr[1]);
        check({tag, ".r2"}, R2, mr[2]);
        check({tag, ".r3"}, R3, mr[3]);
        check({tag, ".cnt"}, {16'd0, Accept_Count}, 32'(mcnt & 16'hFFFF));
    endtask

    // One clock cycle: drive, check ready, clock, update model, check state.
    task automatic step(input string tag, input bit iv, input logic [1:0] s,
                        input logic [31:0] d, input logic [3:0] a,
                        input bit r, input bit full_chk);
        bit rdy;
        bit acc;
        rst      = r;
        In_Valid = iv;
        Selector = s;
        Data     = d;
        Ack      = a;
        rdy      = model_ready(s, a);
        acc      = iv && rdy && !r;
        #1;
        if (!r) check({tag, ".ready"}, {31'd0, In_Ready}, {31'd0, rdy});
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                mv[i] = 1'b0;
                mr[i] = '0;
            end
            mcnt = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc && s == 2'(i)) begin
                    mr[i] = d;
                    mv[i] = 1'b1;
                end else if (a[i]) begin
                    mv[i] = 1'b0;
                end
            end
            mcnt = (mcnt + (acc ? 1 : 0)) & 16'hFFFF;
        end
        #1;
        if (full_chk) check_state(tag);
    endtask

    initial begin
        bit          pend;
        logic [1:0]  ps;
        logic [31:0] pd;
        int          stalls;

        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            mr[i] = 'x;
        end
        @(negedge clk);

        // reset and ready for every selector afterwards
        step("reset", 1'b1, 2'd0, 32'h5555_5555, 4'b1111, 1'b1, 1'b1);
        for (int s = 0; s < 4; s++) begin
            Selector = 2'(s);
            In_Valid = 1'b0;
            Ack      = 4'b0000;
            rst      = 1'b0;
            #1;
            check("post_reset_ready", {31'd0, In_Ready}, 32'd1);
        end

        // first accept
        step("w0", 1'b1, 2'd0, 32'hDEADBEEF, 4'b0000, 1'b0, 1'b1);
        check("w0.r0_literal", R0, 32'hDEADBEEF);
        check("w0.cnt_literal", {16'd0, Accept_Count}, 32'd1);

        // fill remaining channels, then stall on a full channel
        step("w1", 1'b1, 2'd1, 32'hCAFEBABE, 4'b0000, 1'b0, 1'b1);
        step("w2", 1'b1, 2'd2, 32'h0BADF00D, 4'b0000, 1'b0, 1'b1);
        step("w3", 1'b1, 2'd3, 32'h01234567, 4'b0000, 1'b0, 1'b1);
        check("full.valid_literal", {28'd0, Valid}, 32'hF);
        step("stall", 1'b1, 2'd2, 32'hFFFF0000, 4'b0000, 1'b0, 1'b1);
        check("stall.r2_literal", R2, 32'h0BADF00D);
        check("stall.cnt_literal", {16'd0, Accept_Count}, 32'd4);

        // drain and refill channel 3 in one cycle
        step("refill3", 1'b1, 2'd3, 32'h11111111, 4'b1000, 1'b0, 1'b1);
        check("refill3.r3_literal", R3, 32'h11111111);
        check("refill3.cnt_literal", {16'd0, Accept_Count}, 32'd5);

        // drain 0 and 2 together, then ack them again while empty
        step("drain02", 1'b0, 2'd0, 32'h0, 4'b0101, 1'b0, 1'b1);
        check("drain02.valid_literal", {28'd0, Valid}, 32'hA);
        step("ack_empty", 1'b0, 2'd0, 32'h0, 4'b0101, 1'b0, 1'b1);

        // random traffic; producer holds its offer while stalled
        pend = 1'b0;
        ps   = 2'd0;
        pd   = '0;
        for (int n = 0; n < 600; n++) begin
            logic [3:0] a;
            bit         iv;
            bit         r;
            a = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 99) == 0);
            if (!pend) begin
                iv = ($urandom_range(0, 3) != 0);
                ps = 2'($urandom_range(0, 3));
                pd = $urandom;
            end else begin
                iv = 1'b1;
            end
            pend = iv && !model_ready(ps, a) && !r;
            step("rand", iv, ps, pd, a, r, 1'b1);
        end

        // counter wrap with every channel acked each cycle
        step("wrap_reset", 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b1);
        stalls = 0;
        for (int n = 0; n < 65536; n++) begin
            rst      = 1'b0;
            In_Valid = 1'b1;
            Selector = 2'(n % 4);
            Data     = 32'(n);
            Ack      = 4'b1111;
            #1;
            if (In_Ready !== 1'b1) stalls++;
            @(posedge clk);
            mr[n % 4] = 32'(n);
            mv[n % 4] = 1'b1;
            #1;
        end
        for (int i = 0; i < 4; i++) if (i != 3) mv[i] = 1'b0;
        mcnt = 0;
        check("wrap.stalls", 32'(stalls), 32'd0);
        check("wrap.cnt_literal", {16'd0, Accept_Count}, 32'd0);
        check_state("wrap");

        // reset while all four channels are full
        step("f0", 1'b1, 2'd0, 32'hA0A0A0A0, 4'b0000, 1'b0, 1'b1);
        step("f1", 1'b1, 2'd1, 32'hA1A1A1A1, 4'b0000, 1'b0, 1'b1);
        step("f2", 1'b1, 2'd2, 32'hA2A2A2A2, 4'b0000, 1'b0, 1'b1);
        step("f3", 1'b1, 2'd3, 32'hA3A3A3A3, 4'b0000, 1'b0, 1'b1);
        check("f.valid_literal", {28'd0, Valid}, 32'hF);
        step("midrst", 1'b1, 2'd1, 32'h12345678, 4'b0000, 1'b1, 1'b1);
        check("midrst.valid_literal", {28'd0, Valid}, 32'h0);
        step("after_rst", 1'b1, 2'd2, 32'h87654321, 4'b0000, 1'b0, 1'b1);
        check("after_rst.r2_literal", R2, 32'h87654321);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
